// File: rtl/wb_bist_pkg.sv
// Shared types and constants for the Wishbone SRAM BIST master.
// Holds the FSM state encoding and the data pattern codes.
package wb_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_GAP,
        RD,
        RD_GAP,
        FIN
    } state_e;

    localparam logic [1:0] PAT_INDEX   = 2'b00;
    localparam logic [1:0] PAT_CHECKER = 2'b01;
    localparam logic [1:0] PAT_ONES    = 2'b10;
    localparam logic [1:0] PAT_ZEROS   = 2'b11;

    localparam logic [31:0] CHECKER_EVEN = 32'h5555_5555;
    localparam logic [31:0] CHECKER_ODD  = 32'hAAAA_AAAA;

endpackage

// File: rtl/wb_sram_bist_master_if.sv
// Wishbone classic bus between the BIST master and one SRAM wrapper port.
// Signal names follow the initiator's point of view.
interface wb_sram_bist_master_if #(
    parameter int ADDR_W = 10
) ();

    logic              wbm_cyc_o;
    logic              wbm_stb_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [ADDR_W-1:0] wbm_adr_o;
    logic [31:0]       wbm_dat_o;
    logic [31:0]       wbm_dat_i;
    logic              wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_sram_bist_master_patgen.sv
// Maps (pattern, word index) to the 32-bit test word.
// One instance feeds both write data and read compare.
module wb_bist_patgen
    import wb_bist_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [1:0]       pattern_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [31:0]      data_o
);

    always_comb begin
        data_o = 32'h0;
        unique case (pattern_i)
            PAT_INDEX:   data_o = 32'(idx_i);
            PAT_CHECKER: data_o = idx_i[0] ? CHECKER_ODD : CHECKER_EVEN;
            PAT_ONES:    data_o = 32'hFFFF_FFFF;
            PAT_ZEROS:   data_o = 32'h0;
            default:     data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/wb_sram_bist_master.sv
// Wishbone classic BIST initiator: write a pattern over a word range,
// read it back, count mismatches and report pass/fail.
module wb_sram_bist_master
    import wb_bist_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                start_i,
    input  logic [1:0]          pattern_i,
    input  logic [ADDR_W-1:0]   base_adr_i,
    input  logic [CNT_W-1:0]    word_cnt_i,
    wb_sram_bist_master_if.master wbm,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic                timeout_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [ADDR_W-1:0]   first_err_adr_o
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [1:0]        pat_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  idx_q;
    logic [WD_W-1:0]   wdog_q;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              tout_q;
    logic [CNT_W-1:0]  err_q;
    logic [ADDR_W-1:0] ferr_q;

    logic [31:0]       pat_data;
    logic [ADDR_W-1:0] adr_d;
    logic              ack;
    logic              wd_hit;
    logic              more_d;

    wb_bist_patgen #(.IDX_W(CNT_W)) u_patgen (
        .pattern_i (pat_q),
        .idx_i     (idx_q),
        .data_o    (pat_data)
    );

    assign adr_d  = base_q + ADDR_W'({idx_q, 2'b00});
    assign ack    = wbm.wbm_ack_i & stb_q;
    assign wd_hit = (wdog_q == WD_W'(TIMEOUT - 1));
    assign more_d = (idx_q < cnt_q);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            pat_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pat_q  <= pattern_i;
                        base_q <= base_adr_i & ~ADDR_W'(3);
                        cnt_q  <= word_cnt_i;
                        idx_q  <= '0;
                        wdog_q <= '0;
                        err_q  <= '0;
                        ferr_q <= '0;
                        pass_q <= 1'b0;
                        tout_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (word_cnt_i == '0) begin
                            state_q <= FIN;
                        end else begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            we_q    <= 1'b1;
                            state_q <= WR;
                        end
                    end
                end
                WR: begin
                    if (ack) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        idx_q   <= idx_q + CNT_W'(1);
                        state_q <= WR_GAP;
                    end else if (wd_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        tout_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                WR_GAP: begin
                    wdog_q <= '0;
                    cyc_q  <= 1'b1;
                    stb_q  <= 1'b1;
                    if (more_d) begin
                        state_q <= WR;
                    end else begin
                        idx_q   <= '0;
                        we_q    <= 1'b0;
                        state_q <= RD;
                    end
                end
                RD: begin
                    if (ack) begin
                        // Compare against the same patgen word that was written
                        if (wbm.wbm_dat_i != pat_data) begin
                            if (err_q != '1) err_q <= err_q + CNT_W'(1);
                            if (err_q == '0) ferr_q <= adr_d;
                        end
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        idx_q   <= idx_q + CNT_W'(1);
                        state_q <= RD_GAP;
                    end else if (wd_hit) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        tout_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                RD_GAP: begin
                    wdog_q <= '0;
                    if (more_d) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= RD;
                    end else begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    pass_q  <= (err_q == '0) && !tout_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus strobes drop in the reset cycle itself, not one edge later
    assign wbm.wbm_cyc_o = cyc_q & ~wb_rst_i;
    assign wbm.wbm_stb_o = stb_q & ~wb_rst_i;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wbm.wbm_adr_o = adr_d;
    assign wbm.wbm_dat_o = we_q ? pat_data : 32'h0;

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = tout_q;
    assign err_cnt_o       = err_q;
    assign first_err_adr_o = ferr_q;

endmodule
